// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared constants and types for the weight-stationary systolic array, its
//   input-side feeder and its output-side drain.
//   SYS_N     : array dimension (rows/columns)
//   SYS_ABITS : accumulator width per column
//   SYS_WBITS : weight width per processing element
//   fifo_op_e : push/pop combination seen by a FIFO in one cycle
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int unsigned SYS_N     = 2;
   localparam int unsigned SYS_ABITS = 16;
   localparam int unsigned SYS_WBITS = 8;

   // Encoding is {pop, push} so the enum can be cast straight from the strobes.
   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Synchronous DEPTH x WIDTH FIFO. A push while full is accepted only when a
//   pop happens in the same cycle (the pushed word takes the freed slot).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//     push       : write request, wr_data is stored if there is room
//     wr_data    : write data
//     pop        : read acknowledge, ignored when empty
//     rd_data    : head word, zero while empty
//     full/empty : occupancy flags
//     count      : words currently held
// -----------------------------------------------------------------------------
module result_fifo
   import systolic_pkg::*;
#(
   parameter int unsigned WIDTH = SYS_N * SYS_ABITS,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             pop_ok, push_ok;
   fifo_op_e         op;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (PW+1)'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      op       = fifo_op_e'({pop_ok, push_ok});
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      unique case (op)
         FIFO_PUSH: begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + (PW+1)'(1);
         end
         FIFO_POP: begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - (PW+1)'(1);
         end
         FIFO_BOTH: begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; rd_data is masked while empty instead.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

// File: rtl/array_drain.sv
// -----------------------------------------------------------------------------
// array_drain
//   Output-side reader of the systolic array. Column j of a result row leaves
//   the array j cycles after column 0; per-column delay lines realign the row,
//   which is then queued in result_fifo and offered over ready/valid. The array
//   cannot stall, so a row arriving at a full FIFO (with no pop) is dropped and
//   the sticky overflow flag is raised.
//   Ports:
//     clk, reset     : clock, asynchronous active-low reset
//     acc_in_vector  : bottom-edge accumulators, column j at [j*ABITS +: ABITS]
//     in_valid       : column 0 of a new row is present this cycle
//     out_row_vector : head-of-FIFO row, same packing
//     out_valid      : out_row_vector holds a row
//     out_ready      : downstream accepts the row this cycle
//     count          : rows held in the FIFO
//     overflow       : sticky drop flag
//     clear_overflow : synchronous clear of overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module array_drain
   import systolic_pkg::*;
#(
   parameter int unsigned N     = SYS_N,
   parameter int unsigned ABITS = SYS_ABITS,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N*ABITS-1:0]       acc_in_vector,
   input  logic                     in_valid,
   output logic [N*ABITS-1:0]       out_row_vector,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clear_overflow
);

   logic               row_valid;
   logic [N*ABITS-1:0] row_data;
   logic               fifo_full, fifo_empty, pop, drop;
   logic               overflow_q, overflow_d;

   // Valid shift line: N-1 stages, reset so in-flight rows vanish on reset.
   if (N == 1) begin : g_vld_thru
      assign row_valid = in_valid;
   end else begin : g_vld_line
      logic [N-2:0] vld_q, vld_d;

      always_comb begin
         vld_d    = vld_q << 1;
         vld_d[0] = in_valid;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) vld_q <= '0;
         else        vld_q <= vld_d;
      end

      assign row_valid = vld_q[N-2];
   end

   // Data delay lines: column j waits N-1-j cycles, column N-1 is direct.
   for (genvar j = 0; j < N; j++) begin : g_col
      localparam int unsigned DLY = N - 1 - j;
      if (DLY == 0) begin : g_thru
         assign row_data[j*ABITS +: ABITS] = acc_in_vector[j*ABITS +: ABITS];
      end else begin : g_dly
         logic [ABITS-1:0] pipe_q [DLY];
         logic [ABITS-1:0] pipe_d [DLY];

         always_comb begin
            pipe_d[0] = acc_in_vector[j*ABITS +: ABITS];
            for (int unsigned k = 1; k < DLY; k++) begin
               pipe_d[k] = pipe_q[k-1];
            end
         end

         always_ff @(posedge clk) begin
            pipe_q <= pipe_d;
         end

         assign row_data[j*ABITS +: ABITS] = pipe_q[DLY-1];
      end
   end

   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign drop      = row_valid && fifo_full && !pop;

   result_fifo #(
      .WIDTH (N*ABITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push    (row_valid),
      .wr_data (row_data),
      .pop     (pop),
      .rd_data (out_row_vector),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   always_comb begin
      overflow_d = overflow_q;
      if (drop)                overflow_d = 1'b1;
      else if (clear_overflow) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign overflow = overflow_q;

endmodule

// File: tb/tb_array_drain.sv
module tb_array_drain;

   localparam int unsigned N     = 2;
   localparam int unsigned ABITS = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = N * ABITS;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  acc_in_vector;
   logic          in_valid;
   logic [W-1:0]  out_row_vector;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clear_overflow;

   array_drain #(
      .N     (N),
      .ABITS (ABITS),
      .DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (rst_n),
      .acc_in_vector  (acc_in_vector),
      .in_valid       (in_valid),
      .out_row_vector (out_row_vector),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .count          (count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: input history per cycle plus a queue of whole rows.
   logic [W-1:0] mq [$];
   logic         movf;
   logic [W-1:0] ahist [16];
   logic         vhist [16];
   int           cyc;

   typedef struct {
      logic         v;
      logic [W-1:0] acc;
      logic         rdy;
      logic         ev;
      logic [W-1:0] erow;
      logic [CW-1:0] ecnt;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      movf = 1'b0;
      for (int i = 0; i < 16; i++) vhist[i] = 1'b0;
   endtask

   task automatic apply_in(input logic v, input logic [W-1:0] acc, input logic rdy, input logic clr);
      in_valid       = v;
      acc_in_vector  = acc;
      out_ready      = rdy;
      clear_overflow = clr;
      #3;
   endtask

   task automatic check_model();
      if (!rst_n) begin
         chk("rst_valid", out_valid, 0);
         chk("rst_count", count, 0);
         chk("rst_ovf", overflow, 0);
      end else begin
         chk("valid", out_valid, (mq.size() != 0));
         chk("count", count, mq.size());
         chk("overflow", overflow, movf);
         if (mq.size() != 0) chk("row", out_row_vector, mq[0]);
      end
   endtask

   task automatic advance();
      logic [W-1:0] row;
      bit pop, arr, drop;
      int idx, s;
      idx = cyc % 16;
      ahist[idx] = acc_in_vector;
      if (!rst_n) begin
         model_reset();
      end else begin
         vhist[idx] = in_valid;
         s    = cyc - int'(N) + 1;
         pop  = (mq.size() != 0) && out_ready;
         arr  = (s >= 0) ? vhist[s % 16] : 1'b0;
         drop = 1'b0;
         if (pop) void'(mq.pop_front());
         if (arr) begin
            for (int j = 0; j < int'(N); j++)
               row[j*ABITS +: ABITS] = ahist[(s + j) % 16][j*ABITS +: ABITS];
            if (mq.size() < int'(DEPTH)) mq.push_back(row);
            else drop = 1'b1;
         end
         movf = drop ? 1'b1 : (clear_overflow ? 1'b0 : movf);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycle(input logic v, input logic [W-1:0] acc, input logic rdy, input logic clr);
      apply_in(v, acc, rdy, clr);
      check_model();
      advance();
   endtask

   function automatic logic [W-1:0] rnd();
      return W'({$urandom, $urandom});
   endfunction

   logic [W-1:0] r0, r1;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; acc_in_vector = '0;
      out_ready = 1'b0; clear_overflow = 1'b0; cyc = 0;
      model_reset();

      #1;
      chk("por_valid", out_valid, 0);
      chk("por_count", count, 0);
      chk("por_ovf", overflow, 0);
      chk("por_row", out_row_vector, 0);
      @(posedge clk); #1;
      // in_valid high during reset must be ignored
      run_cycle(1, rnd(), 0, 0);
      run_cycle(1, rnd(), 0, 0);
      rst_n = 1'b1;

      // Single row then four back-to-back rows, explicit expectations.
      tbl[0]  = '{1, 32'h0000_0011, 1, 0, 32'h0,         0};
      tbl[1]  = '{0, 32'h0022_0000, 1, 0, 32'h0,         0};
      tbl[2]  = '{0, 32'h0000_0000, 1, 1, 32'h0022_0011, 1};
      tbl[3]  = '{0, 32'h0000_0000, 1, 0, 32'h0,         0};
      tbl[4]  = '{1, 32'h0000_0001, 1, 0, 32'h0,         0};
      tbl[5]  = '{1, 32'h0101_0002, 1, 0, 32'h0,         0};
      tbl[6]  = '{1, 32'h0102_0003, 1, 1, 32'h0101_0001, 1};
      tbl[7]  = '{1, 32'h0103_0004, 1, 1, 32'h0102_0002, 1};
      tbl[8]  = '{0, 32'h0104_0000, 1, 1, 32'h0103_0003, 1};
      tbl[9]  = '{0, 32'h0000_0000, 1, 1, 32'h0104_0004, 1};
      tbl[10] = '{0, 32'h0000_0000, 1, 0, 32'h0,         0};
      for (int i = 0; i < 11; i++) begin
         apply_in(tbl[i].v, tbl[i].acc, tbl[i].rdy, 0);
         chk("tbl_valid", out_valid, tbl[i].ev);
         chk("tbl_count", count, tbl[i].ecnt);
         if (tbl[i].ev) chk("tbl_row", out_row_vector, tbl[i].erow);
         check_model();
         advance();
      end

      // Fill and overflow: five rows with no consumer.
      for (int k = 0; k < 5; k++) run_cycle(1, rnd(), 0, 0);
      for (int k = 0; k < int'(N); k++) run_cycle(0, rnd(), 0, 0);
      chk("fill_count", count, 4);
      chk("fill_ovf", overflow, 1);
      for (int k = 0; k < 6; k++) run_cycle(0, '0, 1, 0);
      chk("drain_count", count, 0);
      chk("drain_ovf_sticky", overflow, 1);

      // Clear without a drop.
      run_cycle(0, '0, 0, 1);
      chk("clear_ovf", overflow, 0);

      // Full with simultaneous push and pop.
      for (int k = 0; k < 4; k++) run_cycle(1, rnd(), 0, 0);
      for (int k = 0; k < int'(N) - 1; k++) run_cycle(0, rnd(), 0, 0);
      chk("full_count", count, 4);
      run_cycle(1, rnd(), 0, 0);
      for (int k = 0; k < int'(N) - 2; k++) run_cycle(0, rnd(), 0, 0);
      run_cycle(0, rnd(), 1, 0);
      chk("pushpop_count", count, 4);
      chk("pushpop_ovf", overflow, 0);

      // Clear in the same cycle as a drop: set wins.
      run_cycle(1, rnd(), 0, 0);
      for (int k = 0; k < int'(N) - 2; k++) run_cycle(0, rnd(), 0, 0);
      run_cycle(0, rnd(), 0, 1);
      chk("clr_drop_ovf", overflow, 1);
      for (int k = 0; k < 6; k++) run_cycle(0, '0, 1, 0);
      run_cycle(0, '0, 0, 1);

      // Reset mid-stream: two rows queued, one in flight.
      run_cycle(1, rnd(), 0, 0);
      run_cycle(1, rnd(), 0, 0);
      for (int k = 0; k < int'(N) - 1; k++) run_cycle(0, rnd(), 0, 0);
      chk("pre_rst_count", count, 2);
      run_cycle(1, rnd(), 0, 0);
      in_valid = 1'b0;
      acc_in_vector = rnd();
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_ovf", overflow, 0);
      model_reset();
      @(posedge clk); #1;
      run_cycle(1, rnd(), 0, 0);
      run_cycle(1, rnd(), 0, 0);
      rst_n = 1'b1;
      r0 = rnd();
      r1 = rnd();
      run_cycle(1, r0, 1, 0);
      run_cycle(0, r1, 1, 0);
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_count", count, 1);
      chk("post_rst_row", out_row_vector, {r1[W-1:ABITS], r0[ABITS-1:0]});
      for (int k = 0; k < 3; k++) run_cycle(0, '0, 1, 0);

      // Randomized traffic, alternating consumer bias so overflow occurs.
      for (int k = 0; k < 600; k++) begin
         logic rdy;
         if ((k / 100) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
         else                    rdy = ($urandom_range(0, 3) == 0);
         run_cycle(logic'($urandom_range(0, 1)), rnd(), rdy,
                   logic'($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_drain.md
# array_drain

Output-side reader for the weight-stationary systolic `array`. Column `j` of a result row leaves the bottom edge of the array `j` cycles after column 0. This block realigns the columns into whole rows and buffers them in a small FIFO. It hands the rows to downstream logic over a ready/valid handshake. The array cannot stall, so when the FIFO is full the block drops the row and reports overflow rather than applying backpressure.

## Interface
- `N`, 2: array dimension (columns per row)
- `ABITS`, 16: accumulator width per column
- `DEPTH`, 4: result FIFO depth in rows, power of two, ≥2
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `acc_in_vector` in N*ABITS: array bottom-edge accumulators, column `j` at bits `[j*ABITS +: ABITS]`
- `in_valid` in 1: column 0 of a new result row is present on `acc_in_vector` this cycle
- `out_row_vector` out N*ABITS: head-of-FIFO row, same column packing as `acc_in_vector`
- `out_valid` out 1: `out_row_vector` holds a valid row
- `out_ready` in 1: downstream accepts the row this cycle
- `count` out $clog2(DEPTH)+1: rows currently held in the FIFO
- `overflow` out 1: sticky flag, set when a row is dropped
- `clear_overflow` in 1: synchronous clear of `overflow`

## Operation
- Deskew:
  - column `j` passes through a `N-1-j` stage register delay line; column `N-1` is undelayed.
  - `in_valid` passes through an `N-1` stage valid shift line.
  - All columns of a row align at the line outputs `N-1` cycles after `in_valid`.
  - Rows may start on consecutive cycles, so up to `N-1` rows can be in flight in the delay lines.
- Push:
  - when the aligned valid is high, the aligned row is written at `wr_ptr`.
  - the write is blocked if `count == DEPTH` and no pop happens in the same cycle.
- Pop: occurs when `out_valid && out_ready`; `rd_ptr` advances.
- Simultaneous push and pop:
  - allowed at any `count`, including full; `count` is unchanged.
  - at full, the pushed row takes the slot freed by the pop, so no drop occurs.
- Drop:
  - a blocked push discards the row and sets `overflow`.
  - FIFO contents and pointers are untouched.
- `clear_overflow`:
  - clears `overflow` the following cycle.
  - if a drop occurs in the same cycle, set wins.
- Pointers: `$clog2(DEPTH)` bits each, wrap modulo `DEPTH`.
- Data handling: values are passed unchanged, with no arithmetic or sign handling.

## Timing
- Reset values: `out_valid`=0, `count`=0, `overflow`=0, `out_row_vector`=0, pointers=0, all valid shift stages=0.
- Delay-line data registers are not reset.
- Latency: `in_valid` in cycle `t` → row written at the edge ending cycle `t+N-1` → `out_valid` high in cycle `t+N`. There is no empty-FIFO bypass.
- Throughput: one row per cycle in and out.
- `out_row_vector`, `out_valid` and `count` are registered or derived from registered state only. There is no combinational path from `out_ready` to `out_valid`.
- `out_row_vector` must hold steady while `out_valid && !out_ready`.
- Reset mid-operation:
  - in-flight rows in the delay lines are lost.
  - the FIFO empties and `overflow` clears.
  - the first `in_valid` after reset deassertion behaves as from power-up.
- `in_valid` high during reset is ignored.

## Structure
- The shared package `systolic_pkg` holds the default `N`, `ABITS` and `WBITS` constants, used by `array`, its feeder and this block.
- One sub-module, `result_fifo`:
  - a synchronous DEPTH×(N*ABITS) FIFO with push, pop, full, empty and count.
  - its write path is reusable by the input-side feeder.
- Deskew delay lines and the overflow flag stay in `array_drain` as generate loops.
- Target size: about 180 lines total.

## Test plan
- Single row, N=2: pulse `in_valid` at t=0 with col0=0x0011, drive col1=0x0022 at t=1, `out_ready`=1 → `out_valid` at t=2, `out_row_vector`=0x0022_0011, `count` back to 0 at t=3.
- Back-to-back: 4 rows on consecutive cycles (col0 values 1,2,3,4; col1 values 0x101–0x104 each one cycle later), `out_ready`=1 → 4 consecutive output beats, correctly paired, in order.
- Fill and overflow: `out_ready`=0, 5 rows → `count`=4, 5th row dropped, `overflow`=1; drain with `out_ready`=1 → rows 1–4 only.
- Full with simultaneous push/pop: `count`=4, push row arriving while `out_ready`=1 → no drop, `count` stays 4, `overflow` stays 0.
- Overflow clear: pulse `clear_overflow` with no drop → `overflow`=0 next cycle. Repeat in the same cycle as a drop → `overflow` remains 1.
- Reset mid-stream: assert `reset`=0 with 2 rows in the FIFO and 1 row in flight → `out_valid`=0 and `count`=0 immediately. After release, a new row appears N cycles after its `in_valid`, with no stale data.
